// File: rtl/usb_tx_pkg.sv
// usb_tx_pkg: shared states, PID/SYNC/CRC5 constants and FSM sequencing helpers for the USB token transmitter.
package usb_tx_pkg;
  typedef enum logic [2:0] {IDLE, SYNC, PID, TOKEN, CRC, EOP_SE0, EOP_J} state_t;
  localparam logic [3:0] PID_OUT   = 4'h1;
  localparam logic [3:0] PID_IN    = 4'h9;
  localparam logic [3:0] PID_SOF   = 4'h5;
  localparam logic [3:0] PID_SETUP = 4'hD;
  localparam logic [7:0] SYNC_BYTE = 8'h80;
  localparam logic [4:0] CRC5_INIT = 5'b11111;
  localparam logic [4:0] CRC5_POLY = 5'b00101;
  localparam int EOP_SE0_BITS = 2;
  function automatic logic [3:0] last_idx(input state_t s);
    return (s == SYNC || s == PID) ? 4'd7 :
           (s == TOKEN) ? 4'd10 :
           (s == CRC) ? 4'd4 :
           (s == EOP_SE0) ? 4'(EOP_SE0_BITS - 1) : 4'd0;
  endfunction
  function automatic state_t next_state(input state_t s);
    return (s == EOP_J) ? IDLE : state_t'(s + 3'd1);
  endfunction
endpackage

// File: rtl/crc_gen_5bit.sv
// crc_gen_5bit: serial USB CRC5 (x^5+x^2+1) shift register, cleared to all ones.
module crc_gen_5bit
  import usb_tx_pkg::*;
(
  input  logic       clk,
  input  logic       n_rst,
  input  logic       clear,
  input  logic       shift,
  input  logic       din,
  output logic [4:0] crc
);
  logic w_fb;
  assign w_fb = din ^ crc[4];
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) crc <= CRC5_INIT;
    else if (clear) crc <= CRC5_INIT;
    else if (shift) crc <= {crc[3:0], 1'b0} ^ (w_fb ? CRC5_POLY : 5'd0);
  end
endmodule

// File: rtl/usb_token_tx.sv
// usb_token_tx: serialises a USB token packet (SYNC, PID, addr/endp, CRC5, EOP) onto NRZI D+/D-.
// Optional bit stuffing is enabled by defining USB_TX_BIT_STUFF_EN.
module usb_token_tx
  import usb_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       tx_start,
  input  logic [3:0] tx_pid,
  input  logic [6:0] tx_addr,
  input  logic [3:0] tx_endp,
  output logic       d_plus,
  output logic       d_minus,
  output logic       tx_busy,
  output logic       tx_done
);
  localparam logic [7:0] RELOAD = 8'(CLKS_PER_BIT - 1);
`ifdef USB_TX_BIT_STUFF_EN
  localparam logic STUFF_EN = 1'b1;
`else
  localparam logic STUFF_EN = 1'b0;
`endif
  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [3:0]  r_idx;
  logic [3:0]  r_pid;
  logic [6:0]  r_addr;
  logic [3:0]  r_endp;
  logic        r_line;
  logic [2:0]  r_ones;
  logic        r_dp, r_dm, r_busy, r_done;
  logic [4:0]  w_crc;
  logic [7:0]  w_pidb;
  logic [10:0] w_tok;
  logic        w_accept, w_tick, w_last, w_stuff, w_adv, w_bit, w_line;
  state_t      w_nstate;
  logic [3:0]  w_nidx;
  assign w_pidb = {~r_pid, r_pid};
  assign w_tok  = {r_endp, r_addr};
  // r_idx names the data bit on the line; a stuffed 0 leaves it (and the state) in place.
  always_comb begin
    w_accept = (r_state == IDLE) && tx_start;
    w_tick   = (r_state != IDLE) && (r_cnt == 8'd0);
    w_last   = (r_idx == last_idx(r_state));
    w_stuff  = STUFF_EN && w_tick && (r_state inside {SYNC, PID, TOKEN, CRC}) && (r_ones == 3'd6);
    w_adv    = w_accept || (w_tick && !w_stuff);
    w_nstate = w_accept ? SYNC : w_last ? next_state(r_state) : r_state;
    w_nidx   = (w_accept || w_last) ? 4'd0 : r_idx + 4'd1;
    w_bit    = (w_nstate == SYNC)  ? SYNC_BYTE[w_nidx[2:0]] :
               (w_nstate == PID)   ? w_pidb[w_nidx[2:0]] :
               (w_nstate == TOKEN) ? w_tok[w_nidx] : ~w_crc[3'd4 - w_nidx[2:0]];
    w_line   = (w_bit && !w_stuff) ? r_line : ~r_line;
  end
  crc_gen_5bit u_crc (
    .clk   (clk),
    .n_rst (n_rst),
    .clear (w_accept),
    .shift (w_adv && (w_nstate == TOKEN)),
    .din   (w_bit),
    .crc   (w_crc)
  );
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= IDLE;
      r_cnt   <= 8'd0;
      r_idx   <= 4'd0;
      r_pid   <= 4'd0;
      r_addr  <= 7'd0;
      r_endp  <= 4'd0;
      r_line  <= 1'b1;
      r_ones  <= 3'd0;
      r_dp    <= 1'b1;
      r_dm    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_cnt  <= (w_accept || w_tick) ? RELOAD : (r_state == IDLE) ? 8'd0 : r_cnt - 8'd1;
      if (w_accept) begin
        r_pid  <= tx_pid;
        r_addr <= tx_addr;
        r_endp <= tx_endp;
        r_busy <= 1'b1;
      end
      if (w_stuff) begin
        r_line <= w_line;
        r_dp   <= w_line;
        r_dm   <= ~w_line;
        r_ones <= 3'd0;
      end
      if (w_adv) begin
        r_state <= w_nstate;
        r_idx   <= w_nidx;
        if (w_nstate == IDLE) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
          r_dp   <= 1'b1;
          r_dm   <= 1'b0;
        end else if (w_nstate == EOP_SE0) begin
          r_dp <= 1'b0;
          r_dm <= 1'b0;
        end else if (w_nstate == EOP_J) begin
          r_line <= 1'b1;
          r_dp   <= 1'b1;
          r_dm   <= 1'b0;
        end else begin
          r_line <= w_line;
          r_dp   <= w_line;
          r_dm   <= ~w_line;
          r_ones <= w_bit ? r_ones + 3'd1 : 3'd0;
        end
      end
    end
  end
  assign d_plus  = r_dp;
  assign d_minus = r_dm;
  assign tx_busy = r_busy;
  assign tx_done = r_done;
endmodule
